// File: rtl/misc_exec_unit_buffered.sv
`default_nettype none
// ============================================================================
// Module      : misc_exec_unit_buffered
// Description : Misc execution unit. Executes NOP, HALT, IN, OUT and FLUSH
//               under an issue/complete handshake. OUT bytes go through a TX
//               FIFO so the core does not wait on the UART. IN/OUT move
//               1..MAX_BYTES bytes per instruction, least significant first.
//               Optional feature macro: MISC_CYCLE_COUNTER_EN adds a 32-bit
//               free-running cycle counter and the RDCYC opcode (9).
// Revision    : 1.0 - initial release
// ============================================================================
module misc_exec_unit_buffered #(
  parameter int TX_DEPTH  = 8,
  parameter int MAX_BYTES = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic [5:0]                  inst_num,
  input  logic [1:0]                  size,
  input  logic [31:0]                 rs,
  input  logic [31:0]                 rd,
  output logic [31:0]                 out,
  output logic                        completed,
  output logic                        halted,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [7:0]                  uart_in_data,
  output logic                        uart_in_valid,
  input  logic                        uart_in_ready,
  output logic                        uart_out_valid,
  input  logic [7:0]                  uart_out_data,
  input  logic                        uart_out_ready
);

  localparam int               c_ADDR_W  = $clog2(TX_DEPTH);
  localparam int               c_PTR_W   = c_ADDR_W + 1;
  localparam logic [c_ADDR_W:0] c_FULL    = c_PTR_W'(TX_DEPTH);
  localparam logic [c_ADDR_W:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [1:0]       c_MAXL    = 2'(MAX_BYTES - 1);

  localparam logic [5:0] c_OP_HALT  = 6'd5;
  localparam logic [5:0] c_OP_IN    = 6'd6;
  localparam logic [5:0] c_OP_OUT   = 6'd7;
  localparam logic [5:0] c_OP_FLUSH = 6'd8;
`ifdef MISC_CYCLE_COUNTER_EN
  localparam logic [5:0] c_OP_RDCYC = 6'd9;
`endif

  // EXEC is the single-cycle slot shared by NOP, HALT, RDCYC and unknown ops
  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_EXEC   = 3'd1;
  localparam logic [2:0] c_S_IN     = 3'd2;
  localparam logic [2:0] c_S_OUT    = 3'd3;
  localparam logic [2:0] c_S_FLUSH  = 3'd4;
  localparam logic [2:0] c_S_HALTED = 3'd5;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic                r_live;
  logic [5:0]          r_op;
  logic [1:0]          r_nlast;
  logic [1:0]          r_k;
  logic [31:0]         r_rs;
  logic [31:0]         r_buf;
  logic [31:0]         r_out;
  logic                r_completed;
  logic                r_halted;
  logic                r_rx_valid;

  logic [7:0]          r_mem [TX_DEPTH];
  logic [c_ADDR_W:0]   r_wptr;
  logic [c_ADDR_W:0]   r_rptr;
  logic [c_ADDR_W:0]   w_level;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic [7:0]          w_tx_byte;

  logic                w_accept;
  logic                w_cap;
  logic                w_last;
  logic [1:0]          w_nlast;
  logic [31:0]         w_in_merged;

`ifdef MISC_CYCLE_COUNTER_EN
  logic [31:0]         r_cyc;
  logic [31:0]         r_cyc_lat;

  // Free-running cycle counter, wraps naturally at 2^32
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_cyc <= '0;
    else          r_cyc <= r_cyc + 32'd1;
  end
`endif

  assign w_level   = r_wptr - r_rptr;
  assign w_empty   = (w_level == '0);
  assign w_full    = (w_level == c_FULL);
  // Fullness uses the registered level, so a same-cycle pop never frees a slot
  assign w_push    = (r_state == c_S_OUT) && !w_full;
  assign w_pop     = !w_empty && uart_in_ready;
  assign w_tx_byte = r_rs[{r_k, 3'b000} +: 8];

  assign w_accept  = issue_valid && issue_ready;
  assign w_cap     = (r_state == c_S_IN) && r_rx_valid && uart_out_ready;
  assign w_last    = (r_k == r_nlast);
  assign w_nlast   = (size > c_MAXL) ? c_MAXL : size;

  assign out            = r_out;
  assign completed      = r_completed;
  assign halted         = r_halted;
  assign tx_level       = w_level;
  assign uart_in_valid  = !w_empty;
  assign uart_in_data   = w_empty ? 8'h00 : r_mem[r_rptr[c_ADDR_W-1:0]];
  assign uart_out_valid = r_rx_valid;

  // Final IN result: buffered lanes with the byte being captured dropped in
  always_comb begin
    w_in_merged = r_buf;
    w_in_merged[{r_k, 3'b000} +: 8] = uart_out_data;
  end

  // FSM state register; r_live holds issue_ready low until the first edge after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_accept) begin
          case (inst_num)
            c_OP_IN:    w_state_nxt = c_S_IN;
            c_OP_OUT:   w_state_nxt = c_S_OUT;
            c_OP_FLUSH: w_state_nxt = c_S_FLUSH;
            default:    w_state_nxt = c_S_EXEC;
          endcase
        end
      end
      c_S_EXEC:   w_state_nxt = (r_op == c_OP_HALT) ? c_S_HALTED : c_S_IDLE;
      c_S_IN:     if (w_cap && w_last)  w_state_nxt = c_S_IDLE;
      c_S_OUT:    if (w_push && w_last) w_state_nxt = c_S_IDLE;
      c_S_FLUSH:  if (w_empty)          w_state_nxt = c_S_IDLE;
      c_S_HALTED: w_state_nxt = c_S_HALTED;
      default:    w_state_nxt = c_S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    issue_ready = r_live && (r_state == c_S_IDLE);
  end

  // Instruction latch, byte sequencing, result and completion pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op        <= '0;
      r_nlast     <= '0;
      r_k         <= '0;
      r_rs        <= '0;
      r_buf       <= '0;
      r_out       <= '0;
      r_completed <= 1'b0;
      r_halted    <= 1'b0;
      r_rx_valid  <= 1'b0;
`ifdef MISC_CYCLE_COUNTER_EN
      r_cyc_lat   <= '0;
`endif
    end else begin
      r_completed <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          if (w_accept) begin
            r_op       <= inst_num;
            r_nlast    <= w_nlast;
            r_k        <= '0;
            r_rs       <= rs;
            r_buf      <= rd;
            r_rx_valid <= (inst_num == c_OP_IN);
`ifdef MISC_CYCLE_COUNTER_EN
            r_cyc_lat  <= r_cyc;
`endif
          end
        end
        c_S_EXEC: begin
          if (r_op == c_OP_HALT) begin
            r_out    <= 32'hFFFF_FFFF;
            r_halted <= 1'b1;
          end
`ifdef MISC_CYCLE_COUNTER_EN
          else if (r_op == c_OP_RDCYC) begin
            r_out       <= r_cyc_lat;
            r_completed <= 1'b1;
          end
`endif
          else begin
            r_completed <= 1'b1;
          end
        end
        c_S_IN: begin
          if (w_cap) begin
            // Drop valid for one cycle after every captured byte
            r_rx_valid <= 1'b0;
            r_buf[{r_k, 3'b000} +: 8] <= uart_out_data;
            if (w_last) begin
              r_out       <= w_in_merged;
              r_completed <= 1'b1;
            end else begin
              r_k <= r_k + 2'd1;
            end
          end else if (!r_rx_valid) begin
            r_rx_valid <= 1'b1;
          end
        end
        c_S_OUT: begin
          if (w_push) begin
            if (w_last) r_completed <= 1'b1;
            else        r_k <= r_k + 2'd1;
          end
        end
        c_S_FLUSH: begin
          if (w_empty) r_completed <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // TX FIFO pointers; the extra top bit separates full from empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
    end
  end

  // TX FIFO storage; contents are don't-care while the slot is not occupied
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[c_ADDR_W-1:0]] <= w_tx_byte;
  end

endmodule
`default_nettype wire
